// File: rtl/conf_pad_driver.sv
// Pad channel driver: maps each configuration byte to a timed pad output level and output-enable-bar.
// Optional PAD_TURNAROUND_EN holds pad_oeb high for two extra cycles when a channel switches from input to output.
module conf_pad_driver #(
   parameter int NCH     = 3,
   parameter int DIVW    = 16,
   parameter int BURST_N = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [31:0]     conf_in,
   input  logic            conf_upd,
   output logic            upd_ack,
   output logic [NCH-1:0] pad_out,
   output logic [NCH-1:0] pad_oeb,
   output logic [NCH-1:0] busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;
   typedef enum logic [1:0] {M_STATIC, M_SQUARE, M_ONESHOT, M_BURST} mode_e;

   localparam int unsigned DMAX       = DIVW - 1;
   localparam logic [3:0]  BURST_LAST = 4'(BURST_N - 1);

   logic [31:0]     conf_q;
   logic            ack_q;
   logic [NCH-1:0] out_q, out_d;
   logic [DIVW-1:0] cnt_q  [NCH];
   logic [DIVW-1:0] cnt_d  [NCH];
   state_e          st_q   [NCH];
   state_e          st_d   [NCH];
   logic [3:0]      pcnt_q [NCH];
   logic [3:0]      pcnt_d [NCH];
   logic [NCH-1:0] restart;

   function automatic logic [DIVW-1:0] tc_mask(input logic [3:0] div);
      int unsigned e;
      logic [31:0] m;
      e = 32'(div);
      if (e > DMAX) e = DMAX;
      m = (32'd1 << e) - 32'd1;
      return m[DIVW-1:0];
   endfunction

   generate
      if (NCH < 4) begin : g_unused
         logic unused_cfg_bits;
         assign unused_cfg_bits = ^{conf_q[31:8*NCH], conf_in[31:8*NCH]};
      end
   endgenerate

   always_comb begin : next_state
      logic [7:0] old_b;
      logic [7:0] new_b;
      logic       tc;
      logic       lvl;
      logic [3:0] last;
      mode_e      mode;
      old_b = '0;
      new_b = '0;
      tc    = 1'b0;
      lvl   = 1'b0;
      last  = '0;
      mode  = M_STATIC;
      for (int unsigned k = 0; k < NCH; k++) begin
         old_b      = conf_q[8*k +: 8];
         new_b      = conf_in[8*k +: 8];
         restart[k] = conf_upd && (new_b != old_b);
         tc         = (cnt_q[k] == tc_mask(old_b[6:3]));
         // a restarting channel takes its entry behaviour from the incoming byte
         mode       = mode_e'(restart[k] ? new_b[2:1] : old_b[2:1]);
         lvl        = restart[k] ? new_b[0] : old_b[0];
         last       = (mode == M_BURST) ? BURST_LAST : 4'd0;

         cnt_d[k]  = cnt_q[k];
         st_d[k]   = st_q[k];
         pcnt_d[k] = pcnt_q[k];
         out_d[k]  = out_q[k];

         if (restart[k]) begin
            cnt_d[k]  = '0;
            pcnt_d[k] = '0;
            if (mode == M_ONESHOT || mode == M_BURST) begin
               st_d[k]  = ACTIVE;
               out_d[k] = ~lvl;
            end else begin
               st_d[k]  = IDLE;
               out_d[k] = lvl;
            end
         end else if (en) begin
            cnt_d[k] = tc ? '0 : cnt_q[k] + 1'b1;
            case (mode)
               M_SQUARE: begin
                  if (tc) out_d[k] = ~out_q[k];
               end
               M_ONESHOT, M_BURST: begin
                  case (st_q[k])
                     ACTIVE: begin
                        if (tc) begin
                           st_d[k]  = GAP;
                           out_d[k] = lvl;
                        end
                     end
                     GAP: begin
                        if (tc) begin
                           if (pcnt_q[k] == last) begin
                              st_d[k] = IDLE;
                           end else begin
                              st_d[k]   = ACTIVE;
                              out_d[k]  = ~lvl;
                              pcnt_d[k] = pcnt_q[k] + 4'd1;
                           end
                        end
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conf_q <= '1;
         ack_q  <= 1'b0;
         out_q  <= '1;
         for (int unsigned k = 0; k < NCH; k++) begin
            cnt_q[k]  <= '0;
            st_q[k]   <= IDLE;
            pcnt_q[k] <= '0;
         end
      end else begin
         ack_q <= conf_upd;
         if (conf_upd) conf_q <= conf_in;
         out_q <= out_d;
         for (int unsigned k = 0; k < NCH; k++) begin
            cnt_q[k]  <= cnt_d[k];
            st_q[k]   <= st_d[k];
            pcnt_q[k] <= pcnt_d[k];
         end
      end
   end

   assign upd_ack = ack_q;
   assign pad_out = out_q;

   always_comb begin
      busy = '0;
      for (int unsigned k = 0; k < NCH; k++) busy[k] = (st_q[k] != IDLE);
   end

`ifdef PAD_TURNAROUND_EN
   logic [1:0] hold_q [NCH];
   logic [1:0] hold_d [NCH];

   // any update that leaves a channel driving re-arms its hold; releasing to input cancels it
   always_comb begin
      for (int unsigned k = 0; k < NCH; k++) begin
         hold_d[k] = hold_q[k];
         if (conf_upd && !conf_in[8*k+7] && (conf_q[8*k+7] || hold_q[k] != 2'd0))
            hold_d[k] = 2'd2;
         else if (conf_upd && conf_in[8*k+7])
            hold_d[k] = 2'd0;
         else if (hold_q[k] != 2'd0)
            hold_d[k] = hold_q[k] - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NCH; k++) hold_q[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < NCH; k++) hold_q[k] <= hold_d[k];
      end
   end

   always_comb begin
      pad_oeb = '0;
      for (int unsigned k = 0; k < NCH; k++)
         pad_oeb[k] = conf_q[8*k+7] | (hold_q[k] != 2'd0);
   end
`else
   always_comb begin
      pad_oeb = '0;
      for (int unsigned k = 0; k < NCH; k++) pad_oeb[k] = conf_q[8*k+7];
   end
`endif

endmodule

// File: tb/tb_conf_pad_driver.sv
// Bench for conf_pad_driver: directed and random updates checked against a time-since-restart reference model.
module tb_conf_pad_driver;
   localparam int NCH = 3;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [31:0]     conf_in;
   logic            conf_upd;
   logic            upd_ack;
   logic [NCH-1:0] pad_out;
   logic [NCH-1:0] pad_oeb;
   logic [NCH-1:0] busy;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // reference state: enabled cycles elapsed since each channel's last restart
   logic [31:0] m_conf;
   int          t      [NCH];
   bit          parked [NCH];
   int          hold   [NCH];
   bit          m_ack;

   conf_pad_driver #(.NCH(NCH), .DIVW(16), .BURST_N(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .conf_in (conf_in),
      .conf_upd(conf_upd),
      .upd_ack (upd_ack),
      .pad_out (pad_out),
      .pad_oeb (pad_oeb),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_conf = '1;
      m_ack  = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         t[k]      = 0;
         parked[k] = 1'b1;
         hold[k]   = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < NCH; k++) begin
         logic [7:0] nb;
         logic [7:0] ob;
         nb = conf_in[8*k +: 8];
         ob = m_conf[8*k +: 8];
         if (conf_upd && nb != ob) begin
            t[k]      = 0;
            parked[k] = 1'b0;
         end else if (en && !parked[k]) begin
            t[k]++;
         end
         if (conf_upd && !nb[7] && (ob[7] || hold[k] > 0)) hold[k] = 2;
         else if (conf_upd && nb[7]) hold[k] = 0;
         else if (hold[k] > 0) hold[k]--;
      end
      if (conf_upd) m_conf = conf_in;
      m_ack = conf_upd;
   endtask

   task automatic check_all(input string tag);
      logic [NCH-1:0] e_out;
      logic [NCH-1:0] e_busy;
      logic [NCH-1:0] e_oeb;
      for (int k = 0; k < NCH; k++) begin
         logic [7:0] b;
         logic       lvl;
         int         mode, d, per, ph, lim;
         b    = m_conf[8*k +: 8];
         lvl  = b[0];
         mode = int'(b[2:1]);
         d    = int'(b[6:3]);
         if (d > 15) d = 15;
         per  = 1 << d;
         ph   = t[k] / per;
         e_busy[k] = 1'b0;
         e_out[k]  = lvl;
         if (parked[k]) begin
            e_out[k] = 1'b1;
         end else if (mode == 1) begin
            e_out[k] = lvl ^ ((ph % 2) == 1);
         end else if (mode >= 2) begin
            lim = (mode == 3) ? 4 : 1;
            if (ph < 2 * lim) begin
               e_busy[k] = 1'b1;
               e_out[k]  = ((ph % 2) == 0) ? ~lvl : lvl;
            end
         end
`ifdef PAD_TURNAROUND_EN
         e_oeb[k] = b[7] | (hold[k] > 0);
`else
         e_oeb[k] = b[7];
`endif
      end
      chk({tag, ".pad_out"}, 32'(pad_out), 32'(e_out));
      chk({tag, ".busy"},    32'(busy),    32'(e_busy));
      chk({tag, ".pad_oeb"}, 32'(pad_oeb), 32'(e_oeb));
      chk({tag, ".upd_ack"}, 32'(upd_ack), 32'(m_ack));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic run(input int n, input string tag);
      repeat (n) step(tag);
   endtask

   task automatic upd(input logic [31:0] w, input string tag);
      conf_in  = w;
      conf_upd = 1'b1;
      step(tag);
      conf_upd = 1'b0;
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      #1 model_reset();
      check_all(tag);
      chk({tag, ".conf_q"}, dut.conf_q, 32'hFFFF_FFFF);
      @(posedge clk);
      #1 check_all(tag);
      rst = 1'b1;
   endtask

   initial begin
      logic [31:0] w;
      rst      = 1'b0;
      en       = 1'b0;
      conf_upd = 1'b0;
      conf_in  = '1;
      model_reset();
      @(posedge clk);
      #1 check_all("reset");
      chk("reset.conf_q", dut.conf_q, 32'hFFFF_FFFF);
      rst = 1'b1;
      en  = 1'b1;
      run(2, "idle_after_reset");

      upd(32'h0000_0001, "static");
      run(2, "static");
      upd(32'h0000_000B, "square");
      run(9, "square");
      upd(32'h0000_040B, "oneshot");
      run(4, "oneshot");

      upd(32'h000E_040B, "burst");
      run(4, "burst");
      en = 1'b0;
      run(3, "freeze");
      en = 1'b1;
      run(1, "burst");
      upd(32'h0000_040B, "abort");
      run(3, "abort");
      upd(32'h000E_040B, "burst_full");
      run(18, "burst_full");

      upd(32'h000E_0480, "oeb_off");
      run(3, "oeb_off");
      upd(32'h000E_0401, "turn");
      run(4, "turn");
      upd(32'h000E_0480, "oeb_off2");
      run(2, "oeb_off2");
      upd(32'h000E_0401, "turn_re");
      upd(32'h000E_0405, "turn_re");
      run(4, "turn_re");
      upd(32'h000E_0480, "oeb_off3");
      upd(32'h000E_0401, "turn_cancel");
      upd(32'h000E_0481, "turn_cancel");
      run(2, "turn_cancel");

      en = 1'b0;
      upd(32'h0006_0401, "en0_restart");
      run(3, "en0_restart");
      en = 1'b1;
      run(4, "en0_restart");

      for (int i = 0; i < 400; i++) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 5) == 0) begin
            w = m_conf;
            for (int k = 0; k < NCH; k++)
               if ($urandom_range(0, 2) != 0)
                  w[8*k +: 8] = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 2)),
                                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            upd(w, "rand");
         end else begin
            step("rand");
         end
      end

      en = 1'b1;
      upd(32'h000E_0000, "pre_reset");
      run(3, "pre_reset");
      async_reset("mid_reset");
      run(3, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/conf_pad_driver.md
Name: conf_pad_driver

Overview:
- Downstream consumer of the 32-bit pad-configuration word produced by the Wishbone configuration path.
- Turns each configuration byte into a driven pad channel: an output level plus an output-enable-bar.
- Each channel runs in one of four modes: static level, square wave, one-shot pulse or pulse burst, each timed by a per-channel power-of-two divider.
- Sits between the configuration register update path and the user I/O pads, in the pad clock domain.

Parameters:
- NCH, 3, number of pad channels; channel k uses configuration byte k.
- DIVW, 16, width of each channel's timing counter; the divider exponent is clamped to DIVW-1.
- BURST_N, 4, number of pulses emitted in burst mode; legal range 1..15.

Ports:
- clk  in  1  pad-domain clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  global run enable; low freezes all counters and holds all outputs.
- conf_in  in  32  new configuration word.
- conf_upd  in  1  single-cycle update strobe; conf_in is valid in the same cycle.
- upd_ack  out  1  one-cycle pulse confirming the update was applied.
- pad_out  out  NCH  pad output levels.
- pad_oeb  out  NCH  pad output-enable-bar, 1 = input/tri-state.
- busy  out  NCH  per-channel pulse or burst in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values:
  - Stored configuration conf_q = 32'hFFFF_FFFF.
  - pad_out = all 1, pad_oeb = all 1.
  - busy = 0, upd_ack = 0.
  - All counters 0; all FSMs in IDLE.
- Configuration byte k fields:
  - bit0 LVL: idle level.
  - bits2:1 MODE: 00 static, 01 square, 10 one-shot, 11 burst.
  - bits6:3 DIV: half-period of 2^DIV clk cycles.
  - bit7 OEB: output-enable-bar.
- Update:
  - conf_upd=1 at edge N loads conf_q <= conf_in.
  - upd_ack=1 during cycle N+1 only.
  - New levels and oeb appear at pad_out/pad_oeb in cycle N+1.
  - conf_upd is accepted regardless of en.
- Per-channel restart: any channel whose byte changed on an update restarts:
  - counter cleared;
  - FSM forced to the mode's entry state;
  - any in-flight pulse or burst aborted with no completion phase.
- Unchanged channels are unaffected by an update.
- Timing counter:
  - Increments each cycle while en=1.
  - Terminal count (tc) = counter equals 2^DIV-1; the counter wraps to 0 on tc.
- Channel FSM states: IDLE, ACTIVE, GAP.
  - Static: pad_out = LVL; FSM stays IDLE; busy = 0.
  - Square:
    - On entry pad_out = LVL; the counter runs.
    - pad_out toggles on every tc, so the period is 2^(DIV+1) cycles.
    - busy = 0.
  - One-shot / burst entry: FSM enters ACTIVE with pad_out = ~LVL and busy = 1.
  - ACTIVE -> GAP on tc; pad_out = LVL.
  - GAP on tc:
    - if the pulse count has reached the limit (1 for one-shot, BURST_N for burst) -> IDLE and busy = 0;
    - else -> ACTIVE and the pulse count increments.
  - Pulse count is 4 bits and clears on entry.
- en=0:
  - Counters, FSMs and pad_out hold their current values.
  - Updates still load; a restarted channel holds its entry state until en=1.
- Reset asserted mid-pulse: all state returns to reset values immediately (asynchronously); no completion phase.
- pad_oeb[k] = OEB of byte k. pad_out is still computed when OEB=1.

Optional Feature:
- Macro: PAD_TURNAROUND_EN.
- Defined: when an update changes a channel's OEB from 1 to 0:
  - pad_oeb for that channel stays 1 for 2 extra cycles (N+1, N+2) while pad_out settles to its new value;
  - pad_oeb drops to 0 in cycle N+3.
  - A further update during the hold restarts the hold.
  - Changes from 0 to 1 take effect immediately in N+1.
- Undefined: pad_oeb follows OEB directly in N+1, and no extra state is present.

Test Plan:
- Reset: assert rst=0 mid-run -> pad_out=3'b111, pad_oeb=3'b111, busy=0 and upd_ack=0 immediately; conf_q reads FFFFFFFF.
- Static update: conf_in=32'h0000_0001 with conf_upd at edge N -> in cycle N+1, upd_ack=1 for one cycle, pad_out[0]=1, pad_out[2:1]=0, pad_oeb=3'b000.
- Square: byte0=8'h0B (LVL=1, square, DIV=1), en=1 -> pad_out[0] toggles every 2 cycles starting at 1, busy[0]=0.
- One-shot: byte1=8'h04 (LVL=0, one-shot, DIV=0) -> pad_out[1]=1 for 1 cycle, then 0; busy[1] high for 2 cycles, then 0.
- Burst with abort and freeze:
  - byte2=8'h0E (burst, DIV=1) -> 4 pulses, each high 2 / low 2 cycles; busy[2] high for 16 cycles.
  - A re-update of byte2 to 8'h00 at pulse 2 -> pad_out[2]=0 and busy[2]=0 next cycle.
  - en=0 mid-burst freezes the pattern exactly.
- Turnaround (PAD_TURNAROUND_EN defined): byte0 changes from 8'h80 to 8'h01 -> pad_out[0]=1 at N+1, pad_oeb[0]=1 through N+2, 0 at N+3; with the macro undefined, pad_oeb[0]=0 at N+1.
